// File: rtl/ws2812_tx_if.sv
// Parallel-frame / status bundle between the game engine and the WS2812 serialiser.
// The master side supplies the frame and refresh request; the slave side drives the LED line.
interface ws2812_tx_if #(
   parameter int NUM_LEDS = 5
);
   logic [24*NUM_LEDS-1:0] GRBSeq;
   logic                   Refresh;
   logic                   Dout;
   logic                   Busy;
   logic                   Done;

   modport master (
      output GRBSeq,
      output Refresh,
      input  Dout,
      input  Busy,
      input  Done
   );

   modport slave (
      input  GRBSeq,
      input  Refresh,
      output Dout,
      output Busy,
      output Done
   );
endinterface

// File: rtl/ws2812_tx.sv
// WS2812 one-wire transmitter: captures a GRB frame on Refresh, sends it MSB first
// with pulse-width coded bits, then holds the line low for the latch interval.
module ws2812_tx #(
   parameter int NUM_LEDS = 5,
   parameter int T0H      = 40,
   parameter int T1H      = 80,
   parameter int TBIT     = 125,
   parameter int TRST     = 8000
) (
   input logic         clk,
   input logic         reset,
   ws2812_tx_if.slave  bus
);
   localparam int FW   = 24 * NUM_LEDS;
   localparam int CMAX = (TBIT > TRST) ? TBIT : TRST;
   localparam int CW   = (CMAX > 2) ? $clog2(CMAX) : 1;
   localparam int BW   = $clog2(FW + 1);

   localparam logic [CW-1:0] TBIT_LAST = CW'(TBIT - 1);
   localparam logic [CW-1:0] TRST_LAST = CW'(TRST - 1);
   localparam logic [CW-1:0] T0H_LEN   = CW'(T0H);
   localparam logic [CW-1:0] T1H_LEN   = CW'(T1H);
   localparam logic [BW-1:0] BIT_LAST  = BW'(FW - 1);

   typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

   state_t          state_reg, state_next;
   logic [FW-1:0]   shift_reg, shift_next;
   logic [BW-1:0]   bit_reg, bit_next;
   logic [CW-1:0]   cyc_reg, cyc_next;
   logic            dout_reg, dout_next;
   logic            done_reg, done_next;
   logic [CW-1:0]   high_len;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         shift_reg <= '0;
         bit_reg   <= '0;
         cyc_reg   <= '0;
         dout_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         shift_reg <= shift_next;
         bit_reg   <= bit_next;
         cyc_reg   <= cyc_next;
         dout_reg  <= dout_next;
         done_reg  <= done_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      shift_next = shift_reg;
      bit_next   = bit_reg;
      cyc_next   = cyc_reg;
      done_next  = 1'b0;
      high_len   = '0;
      dout_next  = 1'b0;

      case (state_reg)
         IDLE: begin
            if (bus.Refresh) begin
               state_next = SEND;
               shift_next = bus.GRBSeq;
               bit_next   = '0;
               cyc_next   = '0;
            end
         end
         SEND: begin
            if (cyc_reg == TBIT_LAST) begin
               cyc_next   = '0;
               shift_next = {shift_reg[FW-2:0], 1'b0};
               bit_next   = bit_reg + 1'b1;
               if (bit_reg == BIT_LAST) begin
                  state_next = LATCH;
               end
            end else begin
               cyc_next = cyc_reg + 1'b1;
            end
         end
         LATCH: begin
            if (cyc_reg == TRST_LAST) begin
               state_next = IDLE;
               cyc_next   = '0;
               done_next  = 1'b1;
            end else begin
               cyc_next = cyc_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase

      // Dout is registered from the upcoming cycle's position, so the line
      // level always matches the counters it is paired with.
      high_len  = shift_next[FW-1] ? T1H_LEN : T0H_LEN;
      dout_next = (state_next == SEND) && (cyc_next < high_len);
   end

   assign bus.Dout = dout_reg;
   assign bus.Busy = (state_reg != IDLE);
   assign bus.Done = done_reg;
endmodule

// File: tb/tb_ws2812_tx.sv
// Directed bench for ws2812_tx: a small-timing instance for frame shape checks and
// a default-parameter instance for full-length timing.
module tb_ws2812_tx;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   ws2812_tx_if #(.NUM_LEDS(1)) bus_s ();
   ws2812_tx_if #(.NUM_LEDS(5)) bus_d ();

   ws2812_tx #(.NUM_LEDS(1), .T0H(2), .T1H(4), .TBIT(6), .TRST(10)) dut_s (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_s.slave)
   );

   ws2812_tx dut_d (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_d.slave)
   );

   int checks = 0;
   int errors = 0;

   logic dout_s [0:399];
   logic busy_s [0:399];
   logic done_s [0:399];

   // Samples the small DUT once per cycle (negedge) starting the cycle after capture.
   task automatic record(input int n, input int chg_at, input int pa, input int pb, input bit hold);
      for (int j = 0; j < n; j++) begin
         @(negedge clk);
         dout_s[j] = bus_s.Dout;
         busy_s[j] = bus_s.Busy;
         done_s[j] = bus_s.Done;
         if (j == chg_at) bus_s.GRBSeq = '0;
         bus_s.Refresh = hold || (j == pa) || (j == pb);
      end
   endtask

   // Leading high run of one 6-cycle bit period; -1 if the line rises again later.
   function automatic int high_time(input int start);
      int run = 0;
      bit low_seen = 0;
      bit bad = 0;
      for (int c = 0; c < 6; c++) begin
         if (dout_s[start + c] === 1'b1) begin
            if (low_seen) bad = 1;
            else run++;
         end else begin
            low_seen = 1;
         end
      end
      return bad ? -1 : run;
   endfunction

   function automatic int busy_len(input int start);
      int n = 0;
      while (start + n < 400 && busy_s[start + n] === 1'b1) n++;
      return n;
   endfunction

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({bus_s.Dout, bus_s.Busy, bus_s.Done} !== 3'b000) begin
         errors++;
         $display("FAIL reset_small outputs got=%b exp=000", {bus_s.Dout, bus_s.Busy, bus_s.Done});
      end
      checks++;
      if ({bus_d.Dout, bus_d.Busy, bus_d.Done} !== 3'b000) begin
         errors++;
         $display("FAIL reset_default outputs got=%b exp=000", {bus_d.Dout, bus_d.Busy, bus_d.Done});
      end
      reset = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if ({bus_s.Dout, bus_s.Busy} !== 2'b00) begin
         errors++;
         $display("FAIL idle_after_reset got=%b exp=00", {bus_s.Dout, bus_s.Busy});
      end
      $display("test_reset done");
   endtask

   task automatic test_frame();
      int ht, exp_ht, dcount;
      bus_s.GRBSeq  = 24'hA5_00_FF;
      bus_s.Refresh = 1'b1;
      record(170, -1, -1, -1, 1'b0);
      checks++;
      if (busy_len(0) != 154) begin
         errors++;
         $display("FAIL frame_busy_len got=%0d exp=154", busy_len(0));
      end
      dcount = 0;
      for (int j = 0; j < 170; j++) if (done_s[j] === 1'b1) dcount++;
      checks++;
      if (dcount != 1 || done_s[154] !== 1'b1) begin
         errors++;
         $display("FAIL frame_done count=%0d at154=%b exp count=1 at154=1", dcount, done_s[154]);
      end
      for (int i = 0; i < 24; i++) begin
         ht = high_time(i * 6);
         exp_ht = (i < 8) ? ((8'hA5 >> (7 - i)) & 1 ? 4 : 2) : ((i < 16) ? 2 : 4);
         checks++;
         if (ht != exp_ht) begin
            errors++;
            $display("FAIL frame_bit%0d high_time got=%0d exp=%0d", i, ht, exp_ht);
         end
      end
      $display("test_frame done: busy=%0d done_count=%0d", busy_len(0), dcount);
   endtask

   task automatic test_capture_hold();
      logic [23:0] exp_bits = 24'hA5_00_FF;
      int ht, exp_ht;
      int bad = 0;
      bus_s.GRBSeq  = 24'hA5_00_FF;
      bus_s.Refresh = 1'b1;
      record(170, 1, -1, -1, 1'b0);
      for (int i = 0; i < 24; i++) begin
         ht = high_time(i * 6);
         exp_ht = exp_bits[23 - i] ? 4 : 2;
         checks++;
         if (ht != exp_ht) begin
            errors++;
            bad++;
            $display("FAIL capture_hold_bit%0d high_time got=%0d exp=%0d", i, ht, exp_ht);
         end
      end
      $display("test_capture_hold done: bad_bits=%0d", bad);
   endtask

   task automatic test_back_to_back();
      int ht, exp_ht, base, w;
      bus_s.GRBSeq  = 24'h80_00_01;
      bus_s.Refresh = 1'b1;
      record(320, -1, -1, -1, 1'b1);
      for (int k = 0; k < 2; k++) begin
         base = 155 * k;
         checks++;
         if (busy_len(base) != 154) begin
            errors++;
            $display("FAIL b2b_frame%0d_busy_len got=%0d exp=154", k, busy_len(base));
         end
         checks++;
         if ({busy_s[base + 154], done_s[base + 154], busy_s[base + 155]} !== 3'b011) begin
            errors++;
            $display("FAIL b2b_frame%0d_gap busy/done/next got=%b exp=011", k,
                     {busy_s[base + 154], done_s[base + 154], busy_s[base + 155]});
         end
         for (int i = 0; i < 24; i++) begin
            ht = high_time(base + i * 6);
            exp_ht = (i == 0 || i == 23) ? 4 : 2;
            checks++;
            if (ht != exp_ht) begin
               errors++;
               $display("FAIL b2b_frame%0d_bit%0d high_time got=%0d exp=%0d", k, i, ht, exp_ht);
            end
         end
      end
      bus_s.Refresh = 1'b0;
      w = 0;
      while (bus_s.Busy === 1'b1 && w < 400) begin
         @(negedge clk);
         w++;
      end
      checks++;
      if (bus_s.Busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_drain busy got=%b exp=0 after %0d cycles", bus_s.Busy, w);
      end
      $display("test_back_to_back done: drain_cycles=%0d", w);
   endtask

   task automatic test_drop();
      int extra_busy = 0;
      int dcount = 0;
      bus_s.GRBSeq  = 24'h3C_C3_5A;
      bus_s.Refresh = 1'b1;
      record(260, -1, 50, 150, 1'b0);
      checks++;
      if (busy_len(0) != 154) begin
         errors++;
         $display("FAIL drop_busy_len got=%0d exp=154", busy_len(0));
      end
      for (int j = 154; j < 260; j++) if (busy_s[j] !== 1'b0 || dout_s[j] !== 1'b0) extra_busy++;
      for (int j = 0; j < 260; j++) if (done_s[j] === 1'b1) dcount++;
      checks++;
      if (extra_busy != 0) begin
         errors++;
         $display("FAIL drop_no_extra_frame active_cycles got=%0d exp=0", extra_busy);
      end
      checks++;
      if (dcount != 1) begin
         errors++;
         $display("FAIL drop_done_count got=%0d exp=1", dcount);
      end
      $display("test_drop done: extra_active=%0d done_count=%0d", extra_busy, dcount);
   endtask

   task automatic test_async_reset();
      int ones = 0;
      bus_s.GRBSeq  = 24'hFF_FF_FF;
      bus_s.Refresh = 1'b1;
      @(negedge clk);
      bus_s.Refresh = 1'b0;
      @(negedge clk);
      checks++;
      if (bus_s.Dout !== 1'b1) begin
         errors++;
         $display("FAIL async_pre_dout got=%b exp=1", bus_s.Dout);
      end
      #1 reset = 1'b1;
      #1;
      checks++;
      if ({bus_s.Dout, bus_s.Busy, bus_s.Done} !== 3'b000) begin
         errors++;
         $display("FAIL async_reset_outputs got=%b exp=000", {bus_s.Dout, bus_s.Busy, bus_s.Done});
      end
      @(negedge clk);
      reset = 1'b0;
      for (int j = 0; j < 200; j++) begin
         @(negedge clk);
         if (bus_s.Dout !== 1'b0 || bus_s.Busy !== 1'b0) ones++;
      end
      checks++;
      if (ones != 0) begin
         errors++;
         $display("FAIL async_post_quiet active_cycles got=%0d exp=0", ones);
      end
      $display("test_async_reset done: post_active=%0d", ones);
   endtask

   task automatic test_default();
      int busy_n = 0;
      bit busy_run = 1;
      int dout_bad = 0;
      int rises = 0;
      int dcount = 0;
      logic prev = 1'b0;
      logic exp_d;
      logic done_at_end = 1'b0;
      bus_d.GRBSeq  = '1;
      bus_d.Refresh = 1'b1;
      @(negedge clk);
      bus_d.Refresh = 1'b0;
      for (int j = 0; j < 23010; j++) begin
         if (j > 0) @(negedge clk);
         if (busy_run && bus_d.Busy === 1'b1) busy_n++;
         else busy_run = 0;
         exp_d = (j < 15000) && ((j % 125) < 80);
         if (bus_d.Dout !== exp_d) dout_bad++;
         if (bus_d.Dout === 1'b1 && prev === 1'b0) rises++;
         prev = bus_d.Dout;
         if (bus_d.Done === 1'b1) dcount++;
         if (j == 23000) done_at_end = bus_d.Done;
      end
      checks++;
      if (busy_n != 23000) begin
         errors++;
         $display("FAIL default_busy_len got=%0d exp=23000", busy_n);
      end
      checks++;
      if (dout_bad != 0) begin
         errors++;
         $display("FAIL default_dout_shape mismatched_cycles got=%0d exp=0", dout_bad);
      end
      checks++;
      if (rises != 120) begin
         errors++;
         $display("FAIL default_pulse_count got=%0d exp=120", rises);
      end
      checks++;
      if (dcount != 1 || done_at_end !== 1'b1) begin
         errors++;
         $display("FAIL default_done count=%0d at23000=%b exp count=1 at23000=1", dcount, done_at_end);
      end
      $display("test_default done: busy=%0d pulses=%0d", busy_n, rises);
   endtask

   initial begin
      reset         = 1'b1;
      bus_s.GRBSeq  = '0;
      bus_s.Refresh = 1'b0;
      bus_d.GRBSeq  = '0;
      bus_d.Refresh = 1'b0;
      repeat (3) @(negedge clk);
      test_reset();
      test_frame();
      test_capture_hold();
      test_back_to_back();
      test_drop();
      test_async_reset();
      test_default();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
